// File: rtl/uart_tx_fifo_if.sv
// Purpose : bundles the producer write port, FIFO status and transmitter handshake of uart_tx_fifo.
// Latency : wires only, no storage.
// Backpressure: none in the bundle itself; the full/overflow flags report drops back to the producer.
// Ports   : wr_data/wr_en (producer -> FIFO), full/empty/count/overflow (status),
//           tx_data/tx_send (FIFO -> transmitter), tx_busy (transmitter -> FIFO).
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]      wr_data;
  logic            wr_en;
  logic            full;
  logic            empty;
  logic [ADDR_W:0] count;
  logic            overflow;
  logic [7:0]      tx_data;
  logic            tx_send;
  logic            tx_busy;

  // Producer + transmitter side
  modport master (
    output wr_data, wr_en, tx_busy,
    input  full, empty, count, overflow, tx_data, tx_send
  );

  // FIFO / send sequencer side
  modport slave (
    input  wr_data, wr_en, tx_busy,
    output full, empty, count, overflow, tx_data, tx_send
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Purpose : circular byte FIFO feeding a UART transmitter through its data/send/busy handshake.
// Latency : first tx_send pulse two cycles after the accepted write; then busy time + 3 cycles per byte.
// Backpressure: writes while full are dropped and latch the sticky overflow flag; no stall to the producer.
// Ports   : clk (rising edge), reset (synchronous, active low),
//           bus (slave modport: wr_data/wr_en in, full/empty/count/overflow out,
//                tx_data/tx_send out, tx_busy in).
module uart_tx_fifo #(
  parameter int ADDR_W    = 4,
  parameter int BUSY_WAIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_fifo_if.slave bus
);

  localparam logic [ADDR_W:0] FULL_CNT   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [7:0]      RETRY_LAST = 8'(BUSY_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_HI,
    S_WAIT_LO
  } state_t;

  logic [7:0]        r_mem [2**ADDR_W];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_overflow;
  logic [7:0]        r_tx_data;
  logic [7:0]        r_retry;
  state_t            r_state;

  state_t            w_state_nxt;
  logic [7:0]        w_retry_nxt;
  logic              w_wr_acc;
  logic              w_pop;
  logic [ADDR_W:0]   w_count_nxt;

  // Acceptance looks only at the registered full flag, so a pop in the
  // same cycle does not free a slot for this write.
  assign w_wr_acc = bus.wr_en && !r_full;
  assign w_pop    = (r_state == S_IDLE) && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_pop})
      2'b10:   w_count_nxt = r_count + (ADDR_W+1)'(1);
      2'b01:   w_count_nxt = r_count - (ADDR_W+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage has no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
      r_tx_data  <= '0;
      r_retry    <= '0;
      r_state    <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
      r_retry <= w_retry_nxt;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FULL_CNT);
      r_empty <= (w_count_nxt == '0);
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (bus.wr_en && r_full) begin
        r_overflow <= 1'b1;
      end
      if (w_pop) begin
        r_tx_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
      end
    end
  end

  // WAIT_HI gives the transmitter BUSY_WAIT cycles to raise busy; if it
  // never does, the same byte is offered again with a fresh send pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry;
    case (r_state)
      S_IDLE: begin
        if (!r_empty) begin
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        w_retry_nxt = '0;
        w_state_nxt = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (bus.tx_busy) begin
          w_state_nxt = S_WAIT_LO;
        end else if (r_retry == RETRY_LAST) begin
          w_state_nxt = S_SEND;
        end else begin
          w_retry_nxt = r_retry + 8'd1;
        end
      end
      S_WAIT_LO: begin
        if (!bus.tx_busy) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.full     = r_full;
  assign bus.empty    = r_empty;
  assign bus.count    = r_count;
  assign bus.overflow = r_overflow;
  assign bus.tx_data  = r_tx_data;
  assign bus.tx_send  = (r_state == S_SEND);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Purpose : self-checking bench for uart_tx_fifo with a behavioural transmitter busy responder.
// Latency : n/a.
// Backpressure: n/a.
module tb_uart_tx_fifo;
  localparam int ADDR_W    = 4;
  localparam int BUSY_WAIT = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  uart_tx_fifo #(.ADDR_W(ADDR_W), .BUSY_WAIT(BUSY_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Transmitter model: busy rises the cycle after a send pulse and lasts busy_len cycles.
  logic man_busy  = 1'b0;
  logic resp_busy = 1'b0;
  bit   busy_auto = 1'b0;
  bit   busy_mute = 1'b0;
  int   busy_len  = 10;
  int   busy_dly  = 0;
  assign bus.tx_busy = busy_auto ? resp_busy : man_busy;

  always begin : responder
    int l;
    int d;
    @(negedge clk);
    if (reset && busy_auto && !busy_mute && bus.tx_send) begin
      l = busy_len;
      d = busy_dly;
      @(posedge clk);
      repeat (d) @(posedge clk);
      #1 resp_busy = 1'b1;
      repeat (l) @(posedge clk);
      #1 resp_busy = 1'b0;
    end
  end

  // Observation side: every send pulse, every newly offered byte, stream bookkeeping.
  int         cyc = 0;
  int         wr_seen = 0;
  int         pops = 0;
  bit         stream_on = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         pulse_cyc[$];
  logic [7:0] pulse_dat[$];
  bit         in_xfer = 1'b0;
  bit         busy_hi = 1'b0;
  logic [7:0] held = 8'h00;

  always @(posedge clk) cyc++;
  always @(posedge clk) if (stream_on && reset && bus.wr_en) wr_seen++;

  always @(negedge clk) begin
    if (!reset) begin
      in_xfer = 1'b0;
      busy_hi = 1'b0;
    end else begin
      if (in_xfer) chk("data_stable", bus.tx_data, held);
      if (bus.tx_send) begin
        chk("send_while_busy", bus.tx_busy, 0);
        pulse_cyc.push_back(cyc);
        pulse_dat.push_back(bus.tx_data);
        if (!in_xfer) begin
          in_xfer = 1'b1;
          busy_hi = 1'b0;
          held    = bus.tx_data;
          got_q.push_back(bus.tx_data);
          if (stream_on) begin
            pops++;
            if (exp_q.size() == 0) chk("stream_extra", 1, 0);
            else chk("stream_byte", bus.tx_data, exp_q.pop_front());
          end
        end
      end else if (in_xfer) begin
        if (bus.tx_busy) busy_hi = 1'b1;
        else if (busy_hi) in_xfer = 1'b0;
      end
      if (stream_on) begin
        chk("stream_count", bus.count, wr_seen - pops);
        chk("stream_ovf", bus.overflow, 0);
      end
    end
  end

  // Random producer: keeps at most `limit` bytes outstanding so nothing is ever dropped,
  // and the expected output is simply every written byte in write order.
  task automatic run_stream(input int n, input int limit, input int gap_max);
    int tmo;
    logic [7:0] b;
    exp_q.delete();
    wr_seen   = 0;
    pops      = 0;
    busy_auto = 1'b1;
    stream_on = 1'b1;
    for (int i = 0; i < n; ) begin
      if ((i - pops) < limit && $urandom_range(0, gap_max) == 0) begin
        b = 8'($urandom);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        exp_q.push_back(b);
        i++;
      end else begin
        bus.wr_en = 1'b0;
      end
      busy_len = $urandom_range(1, 6);
      busy_dly = $urandom_range(0, 2);
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    tmo = 0;
    while ((exp_q.size() != 0 || in_xfer) && tmo < 2000) begin
      @(negedge clk);
      tmo++;
    end
    chk("stream_drain", tmo < 2000, 1);
    stream_on = 1'b0;
    chk("stream_end_count", bus.count, 0);
    chk("stream_end_empty", bus.empty, 1);
    chk("stream_end_ovf", bus.overflow, 0);
  endtask

  typedef struct {
    logic            wr_en;
    logic [7:0]      wr_data;
    logic            busy;
    logic            exp_send;
    logic [ADDR_W:0] exp_count;
    logic            exp_empty;
    logic [7:0]      exp_data;
  } vec_t;

  vec_t       vt[15];
  logic [7:0] sim_exp[2];
  int         s;
  int         tmo;
  int         n_pulse;

  initial begin
    // Single byte 0x8E, busy driven by the table: high on the 10 edges after the SEND cycle.
    vt[0] = '{1'b1, 8'h8E, 1'b0, 1'b0, 5'd1, 1'b0, 8'h00};
    vt[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1, 8'h8E};
    vt[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 8'h8E};
    for (int i = 3; i <= 12; i++) vt[i] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 8'h8E};
    vt[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 8'h8E};
    vt[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 8'h8E};

    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    reset       = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_send", bus.tx_send, 0);
    chk("rst_data", bus.tx_data, 0);
    reset = 1'b1;

    // Table: one byte through the full handshake.
    for (int i = 0; i < 15; i++) begin
      bus.wr_en   = vt[i].wr_en;
      bus.wr_data = vt[i].wr_data;
      man_busy    = vt[i].busy;
      @(negedge clk);
      chk($sformatf("vec%0d_send", i), bus.tx_send, vt[i].exp_send);
      chk($sformatf("vec%0d_count", i), bus.count, vt[i].exp_count);
      chk($sformatf("vec%0d_empty", i), bus.empty, vt[i].exp_empty);
      chk($sformatf("vec%0d_data", i), bus.tx_data, vt[i].exp_data);
    end
    bus.wr_en = 1'b0;

    // Write lands on the same edge as the pop with count=1.
    busy_auto = 1'b1;
    busy_len  = 10;
    busy_dly  = 0;
    got_q.delete();
    sim_exp[0] = 8'h3C;
    sim_exp[1] = 8'hC3;
    bus.wr_en   = 1'b1;
    bus.wr_data = sim_exp[0];
    @(negedge clk);
    chk("sim_count_a", bus.count, 1);
    bus.wr_data = sim_exp[1];
    @(negedge clk);
    chk("sim_count_b", bus.count, 1);
    chk("sim_send", bus.tx_send, 1);
    chk("sim_data", bus.tx_data, sim_exp[0]);
    bus.wr_en = 1'b0;
    repeat (40) @(negedge clk);
    chk("sim_nsent", got_q.size(), 2);
    for (int k = 0; k < got_q.size() && k < 2; k++) chk("sim_order", got_q[k], sim_exp[k]);

    // Transmitter silent for 20 cycles: the same byte is re-offered every BUSY_WAIT+1 cycles.
    got_q.delete();
    pulse_cyc.delete();
    pulse_dat.delete();
    busy_mute   = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hA5;
    @(negedge clk);
    bus.wr_data = 8'h5A;
    @(negedge clk);
    bus.wr_en = 1'b0;
    tmo = 0;
    while (pulse_cyc.size() == 0 && tmo < 10) begin
      @(negedge clk);
      tmo++;
    end
    chk("retry_first_seen", pulse_cyc.size() > 0, 1);
    s = (pulse_cyc.size() > 0) ? pulse_cyc[0] : cyc;
    repeat (20) @(negedge clk);
    chk("retry_count_held", bus.count, 1);
    chk("retry_one_popped", got_q.size(), 1);
    busy_mute = 1'b0;
    repeat (60) @(negedge clk);
    chk("retry_npulse", pulse_cyc.size(), 5);
    chk("retry_first_cyc", pulse_cyc.size() > 0 ? pulse_cyc[0] : -1, s);
    for (int k = 1; k < 4 && k < pulse_cyc.size(); k++) begin
      chk("retry_gap", pulse_cyc[k] - pulse_cyc[k-1], BUSY_WAIT + 1);
      chk("retry_same_data", pulse_dat[k], 8'hA5);
    end
    if (pulse_dat.size() >= 5) chk("retry_next_byte", pulse_dat[4], 8'h5A);
    chk("retry_nsent", got_q.size(), 2);

    // Burst: the first byte leaves for tx_data one edge in and the second after the
    // 10-cycle busy window, so 18 back-to-back writes fill all 16 entries.
    got_q.delete();
    for (int k = 0; k < 18; k++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(k);
      @(negedge clk);
      if (k == 16) begin
        chk("burst_count_17", bus.count, 15);
        chk("burst_notfull_17", bus.full, 0);
      end
    end
    chk("burst_full", bus.full, 1);
    chk("burst_count", bus.count, 16);
    chk("burst_ovf_pre", bus.overflow, 0);
    bus.wr_data = 8'hEE;
    @(negedge clk);
    bus.wr_en = 1'b0;
    chk("burst_ovf", bus.overflow, 1);
    chk("burst_count_drop", bus.count, 16);
    tmo = 0;
    while ((got_q.size() < 18 || in_xfer) && tmo < 400) begin
      @(negedge clk);
      tmo++;
    end
    chk("burst_drain", tmo < 400, 1);
    repeat (5) @(negedge clk);
    chk("burst_nsent", got_q.size(), 18);
    for (int k = 0; k < got_q.size(); k++) chk("burst_order", got_q[k], k);
    chk("burst_empty", bus.empty, 1);
    chk("burst_ovf_sticky", bus.overflow, 1);

    // Reset while waiting for busy to fall, five bytes still queued.
    for (int k = 0; k < 6; k++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(8'h60 + k);
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    chk("rstx_count_pre", bus.count, 5);
    reset = 1'b0;
    @(negedge clk);
    chk("rstx_count", bus.count, 0);
    chk("rstx_empty", bus.empty, 1);
    chk("rstx_full", bus.full, 0);
    chk("rstx_ovf", bus.overflow, 0);
    chk("rstx_send", bus.tx_send, 0);
    chk("rstx_data", bus.tx_data, 0);
    reset   = 1'b1;
    n_pulse = pulse_cyc.size();
    repeat (40) @(negedge clk);
    chk("rstx_no_send", pulse_cyc.size(), n_pulse);

    // Pointer wrap with small occupancy, then a deeper random stream.
    run_stream(40, 4, 2);
    run_stream(80, 14, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
